decode_hazard_unit: RTL

Parametrised decode stage for the pipelined MIPS core. It classifies the instruction in D into a one-hot operation vector, with an optional extended ISA. It also tracks in-flight register writers in E and M through a Tnew/Tuse scoreboard, raises `stall_d` on data hazards, and registers the decoded fields into the D/E pipeline register, inserting bubbles on stall or flush.

---
 rtl/decode_hazard_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_hazard_unit.sv
// Decode stage of the pipelined MIPS core: one-hot instruction class, a two-slot
// Tnew/Tuse scoreboard over E and M, and the D/E pipeline register with bubble insertion.
module decode_hazard_unit #(
    parameter logic EXT_ISA   = 1'b1,
    parameter logic HAZARD_EN = 1'b1,
    parameter int   LOAD_TNEW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    input  logic        flush_e,
    output logic [13:0] op_d,
    output logic        illegal_d,
    output logic        stall_d,
    output logic [13:0] op_e,
    output logic [4:0]  rs_e,
    output logic [4:0]  rt_e,
    output logic [4:0]  wa_e,
    output logic        valid_e
);

    localparam int OP_ADDU  = 0;
    localparam int OP_SUBU  = 1;
    localparam int OP_ORI   = 2;
    localparam int OP_LW    = 3;
    localparam int OP_SW    = 4;
    localparam int OP_BEQ   = 5;
    localparam int OP_LUI   = 6;
    localparam int OP_JAL   = 7;
    localparam int OP_JR    = 8;
    localparam int OP_ADDIU = 9;
    localparam int OP_SLT   = 10;
    localparam int OP_SLL   = 11;
    localparam int OP_J     = 12;
    localparam int OP_BNE   = 13;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    localparam logic [1:0]  LW_TNEW = 2'(LOAD_TNEW);
    localparam logic [13:0] OP_MASK = EXT_ISA ? 14'h3FFF : 14'h01FF;

    // Instruction fields
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;

    assign w_opcode = instr_d[31:26];
    assign w_funct  = instr_d[5:0];
    assign w_rs     = instr_d[25:21];
    assign w_rt     = instr_d[20:16];
    assign w_rd     = instr_d[15:11];

    // Decode
    logic [13:0] w_op_raw;

    always_comb begin
        w_op_raw = '0;
        if (w_opcode == OPC_RTYPE) begin
            w_op_raw[OP_ADDU] = (w_funct == FN_ADDU);
            w_op_raw[OP_SUBU] = (w_funct == FN_SUBU);
            w_op_raw[OP_JR]   = (w_funct == FN_JR);
            w_op_raw[OP_SLT]  = (w_funct == FN_SLT);
            w_op_raw[OP_SLL]  = (w_funct == FN_SLL);
        end
        w_op_raw[OP_ORI]   = (w_opcode == OPC_ORI);
        w_op_raw[OP_LW]    = (w_opcode == OPC_LW);
        w_op_raw[OP_SW]    = (w_opcode == OPC_SW);
        w_op_raw[OP_BEQ]   = (w_opcode == OPC_BEQ);
        w_op_raw[OP_LUI]   = (w_opcode == OPC_LUI);
        w_op_raw[OP_JAL]   = (w_opcode == OPC_JAL);
        w_op_raw[OP_ADDIU] = (w_opcode == OPC_ADDIU);
        w_op_raw[OP_J]     = (w_opcode == OPC_J);
        w_op_raw[OP_BNE]   = (w_opcode == OPC_BNE);
    end

    // Without the extension the all-zero word lands here as a masked sll, i.e. a legal nop
    assign op_d      = w_op_raw & OP_MASK;
    assign illegal_d = valid_d && (instr_d != 32'd0) && (op_d == 14'd0);

    // Operand usage and Tuse
    logic       w_rs_used;
    logic [1:0] w_rs_tuse;
    logic       w_rt_used;
    logic [1:0] w_rt_tuse;

    always_comb begin
        w_rs_used = 1'b0;
        w_rs_tuse = 2'd0;
        if (op_d[OP_BEQ] || op_d[OP_BNE] || op_d[OP_JR]) begin
            w_rs_used = 1'b1;
            w_rs_tuse = 2'd0;
        end else if (op_d[OP_ADDU] || op_d[OP_SUBU] || op_d[OP_SLT] || op_d[OP_ORI] ||
                     op_d[OP_ADDIU] || op_d[OP_LW] || op_d[OP_SW]) begin
            w_rs_used = 1'b1;
            w_rs_tuse = 2'd1;
        end
    end

    always_comb begin
        w_rt_used = 1'b0;
        w_rt_tuse = 2'd0;
        if (op_d[OP_BEQ] || op_d[OP_BNE]) begin
            w_rt_used = 1'b1;
            w_rt_tuse = 2'd0;
        end else if (op_d[OP_ADDU] || op_d[OP_SUBU] || op_d[OP_SLT] || op_d[OP_SLL]) begin
            w_rt_used = 1'b1;
            w_rt_tuse = 2'd1;
        end else if (op_d[OP_SW]) begin
            w_rt_used = 1'b1;
            w_rt_tuse = 2'd2;
        end
    end

    // Write address and Tnew at E
    logic [4:0] w_wa_d;
    logic [1:0] w_tnew_d;

    always_comb begin
        w_wa_d   = 5'd0;
        w_tnew_d = 2'd0;
        if (op_d[OP_ADDU] || op_d[OP_SUBU] || op_d[OP_SLT] || op_d[OP_SLL]) begin
            w_wa_d   = w_rd;
            w_tnew_d = 2'd1;
        end else if (op_d[OP_ORI] || op_d[OP_LUI] || op_d[OP_ADDIU]) begin
            w_wa_d   = w_rt;
            w_tnew_d = 2'd1;
        end else if (op_d[OP_LW]) begin
            w_wa_d   = w_rt;
            w_tnew_d = LW_TNEW;
        end else if (op_d[OP_JAL]) begin
            w_wa_d   = 5'd31;
            w_tnew_d = 2'd0;
        end
    end

    // Scoreboard and D/E register state
    logic [13:0] r_op_e;
    logic [4:0]  r_rs_e;
    logic [4:0]  r_rt_e;
    logic [4:0]  r_wa_e;
    logic [1:0]  r_tnew_e;
    logic        r_valid_e;
    logic [4:0]  r_wa_m;
    logic [1:0]  r_tnew_m;

    logic [1:0][4:0] w_slot_wa;
    logic [1:0][1:0] w_slot_tnew;
    logic [1:0]      w_hit_rs;
    logic [1:0]      w_hit_rt;

    assign w_slot_wa[0]   = r_wa_e;
    assign w_slot_tnew[0] = r_tnew_e;
    assign w_slot_wa[1]   = r_wa_m;
    assign w_slot_tnew[1] = r_tnew_m;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign w_hit_rs[gi] = w_rs_used && (w_rs != 5'd0) && (w_rs == w_slot_wa[gi]) &&
                                  (w_slot_tnew[gi] > w_rs_tuse);
            assign w_hit_rt[gi] = w_rt_used && (w_rt != 5'd0) && (w_rt == w_slot_wa[gi]) &&
                                  (w_slot_tnew[gi] > w_rt_tuse);
        end
    endgenerate

    logic w_hazard;
    logic w_load;

    assign w_hazard = (|w_hit_rs) || (|w_hit_rt);
    assign stall_d  = HAZARD_EN && valid_d && w_hazard;
    // Illegal words are nops, so they enter E as a bubble rather than a valid instruction
    assign w_load   = valid_d && !illegal_d && !stall_d && !flush_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_e    <= '0;
            r_rs_e    <= '0;
            r_rt_e    <= '0;
            r_wa_e    <= '0;
            r_tnew_e  <= '0;
            r_valid_e <= 1'b0;
            r_wa_m    <= '0;
            r_tnew_m  <= '0;
        end else begin
            // M advances every edge regardless of stall or flush
            r_wa_m   <= r_wa_e;
            r_tnew_m <= (r_tnew_e == 2'd0) ? 2'd0 : r_tnew_e - 2'd1;
            if (w_load) begin
                r_op_e    <= op_d;
                r_rs_e    <= w_rs;
                r_rt_e    <= w_rt;
                r_wa_e    <= w_wa_d;
                r_tnew_e  <= w_tnew_d;
                r_valid_e <= 1'b1;
            end else begin
                r_op_e    <= '0;
                r_rs_e    <= '0;
                r_rt_e    <= '0;
                r_wa_e    <= '0;
                r_tnew_e  <= '0;
                r_valid_e <= 1'b0;
            end
        end
    end

    assign op_e    = r_op_e;
    assign rs_e    = r_rs_e;
    assign rt_e    = r_rt_e;
    assign wa_e    = r_wa_e;
    assign valid_e = r_valid_e;

endmodule
